// File: rtl/alu16_sequencer_pkg.sv
// Shared definitions for the 16-bit sequencer: ALU opcodes and sizes, flag bit
// positions, sequencer op codes and FSM states.
package alu16_sequencer_pkg;

  // Bit positions inside the 4-bit ZNHC flag nibble.
  localparam int unsigned F_Z = 3;
  localparam int unsigned F_N = 2;
  localparam int unsigned F_H = 1;
  localparam int unsigned F_C = 0;

  // 8-bit ALU opcodes. The ALU computes data1 <op> data0.
  localparam logic [4:0] AluPass0 = 5'd0;
  localparam logic [4:0] AluAdd   = 5'd1;
  localparam logic [4:0] AluAdc   = 5'd2;
  localparam logic [4:0] AluSub   = 5'd3;
  localparam logic [4:0] AluSbc   = 5'd4;

  // ALU size selects.
  localparam logic [1:0] AluSize8    = 2'd0;
  localparam logic [1:0] AluSize16   = 2'd1;
  localparam logic [1:0] AluSizeSpec = 2'd2;

  // Sequencer request op codes.
  typedef enum logic [1:0] {
    SeqOpAdd16 = 2'd0,
    SeqOpInc16 = 2'd1,
    SeqOpDec16 = 2'd2,
    SeqOpAddSp = 2'd3
  } seq_op_e;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLow  = 2'd1,
    StHigh = 2'd2,
    StResp = 2'd3
  } seq_state_e;

endpackage

// File: rtl/alu16_sequencer.sv
// Two-pass 16-bit arithmetic sequencer driving an external 8-bit ALU: low byte
// first, then high byte with the low-pass carry/borrow chained in.
module alu16_sequencer
  import alu16_sequencer_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [3:0]  req_flags,
  output logic [4:0]  alu_op,
  output logic [7:0]  alu_data0,
  output logic [7:0]  alu_data1,
  output logic [1:0]  alu_size,
  output logic [3:0]  alu_flags,
  input  logic [7:0]  alu_result,
  input  logic [3:0]  alu_result_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic [3:0]  rsp_flags
);

  seq_state_e  state_q, state_d;
  seq_op_e     op_q;
  logic [15:0] a_q, b_q;
  logic [3:0]  req_flags_q;
  logic [7:0]  res_lo_q, res_hi_q;
  // Only H and C of each pass feed the response; {H, C}.
  logic [1:0]  hc_lo_q, hc_hi_q;

  logic accept;
  assign accept = req_valid && req_ready;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Request, per-pass result and flag latches.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q        <= SeqOpAdd16;
      a_q         <= '0;
      b_q         <= '0;
      req_flags_q <= '0;
      res_lo_q    <= '0;
      res_hi_q    <= '0;
      hc_lo_q     <= '0;
      hc_hi_q     <= '0;
    end else begin
      if (accept) begin
        op_q        <= seq_op_e'(req_op);
        a_q         <= req_a;
        b_q         <= req_b;
        req_flags_q <= req_flags;
      end
      if (state_q == StLow) begin
        res_lo_q <= alu_result;
        hc_lo_q  <= {alu_result_flags[F_H], alu_result_flags[F_C]};
      end
      if (state_q == StHigh) begin
        res_hi_q <= alu_result;
        hc_hi_q  <= {alu_result_flags[F_H], alu_result_flags[F_C]};
      end
    end
  end

  // Next-state logic and ALU drive for each pass.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_op    = AluPass0;
    alu_data0 = 8'h00;
    alu_data1 = 8'h00;
    alu_size  = AluSize8;
    alu_flags = 4'h0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) state_d = StLow;
      end
      StLow: begin
        alu_data1 = a_q[7:0];
        alu_size  = AluSize16;
        unique case (op_q)
          SeqOpAdd16: begin
            alu_op    = AluAdd;
            alu_data0 = b_q[7:0];
          end
          SeqOpInc16: begin
            alu_op    = AluAdd;
            alu_data0 = 8'h01;
          end
          SeqOpDec16: begin
            alu_op    = AluSub;
            alu_data0 = 8'h01;
          end
          SeqOpAddSp: begin
            alu_op    = AluAdd;
            alu_data0 = b_q[7:0];
            alu_size  = AluSizeSpec;
          end
        endcase
        state_d = StHigh;
      end
      StHigh: begin
        alu_data1 = a_q[15:8];
        alu_size  = AluSize16;
        // Low-pass C goes in unmodified; for SBC it acts as borrow.
        alu_flags = {req_flags_q[F_Z], 1'b0, 1'b0, hc_lo_q[0]};
        unique case (op_q)
          SeqOpAdd16: begin
            alu_op    = AluAdc;
            alu_data0 = b_q[15:8];
          end
          SeqOpInc16: begin
            alu_op    = AluAdc;
            alu_data0 = 8'h00;
          end
          SeqOpDec16: begin
            alu_op    = AluSbc;
            alu_data0 = 8'h00;
          end
          SeqOpAddSp: begin
            alu_op    = AluAdc;
            alu_data0 = {8{b_q[7]}};
          end
        endcase
        state_d = StResp;
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = StIdle;
      end
    endcase
  end

  assign rsp_data = {res_hi_q, res_lo_q};

  // Final flags: ADD16 keeps Z, ADDSP reports the low pass, INC/DEC leave flags alone.
  always_comb begin
    rsp_flags = 4'h0;
    unique case (op_q)
      SeqOpAdd16: rsp_flags = {req_flags_q[F_Z], 1'b0, hc_hi_q};
      SeqOpInc16: rsp_flags = req_flags_q;
      SeqOpDec16: rsp_flags = req_flags_q;
      SeqOpAddSp: rsp_flags = {2'b00, hc_lo_q};
    endcase
  end

endmodule

// File: doc/alu16_sequencer.md
Name: alu16_sequencer

Overview:
- Initiator side of the 8-bit ALU interface.
- Accepts a 16-bit arithmetic request over a valid/ready handshake and drives the combinational 8-bit ALU for two passes: low byte, then high byte with carry chained.
- Returns the 16-bit result and final ZNHC flags over a valid/ready response channel.
- Sits between the CPU control unit and the ALU. Serves ADD HL,rr; INC rr; DEC rr; ADD SP,e8.

Parameters:
F_Z, 3, Z flag bit index in the 4-bit flag nibble
F_N, 2, N flag bit index
F_H, 1, H flag bit index
F_C, 0, C flag bit index

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  sequencer can accept a request
req_op  input  2  0=ADD16, 1=INC16, 2=DEC16, 3=ADDSP
req_a  input  16  first operand (HL or SP or rr)
req_b  input  16  second operand (rr for ADD16; e8 in [7:0] for ADDSP; ignored otherwise)
req_flags  input  4  current ZNHC flags
alu_op  output  5  ALU opcode (cpu.vh ALU_* codes)
alu_data0  output  8  ALU operand 0
alu_data1  output  8  ALU operand 1
alu_size  output  2  ALU_SIZE_8/16/SPEC
alu_flags  output  4  flags presented to ALU
alu_result  input  8  ALU data result
alu_result_flags  input  4  ALU flags result
rsp_valid  output  1  result available
rsp_ready  input  1  consumer accepts result
rsp_data  output  16  16-bit result
rsp_flags  output  4  final ZNHC flags

Behaviour:
- FSM states: IDLE, LOW, HIGH, RESP.
- req_ready = (state==IDLE). On req_valid&req_ready: latch req_op/a/b/flags; go to LOW.
- LOW (one cycle) drives the ALU as follows; at the clock edge, latch alu_result into res_lo and alu_result_flags into flags_lo; go to HIGH.
  - ADD16: ALU_ADD, data1=a[7:0], data0=b[7:0], size 16.
  - INC16: ALU_ADD, data0=8'h01, size 16.
  - DEC16: ALU_SUB, data0=8'h01, size 16.
  - ADDSP: ALU_ADD, data0=b[7:0], size SPEC.
- HIGH (one cycle): alu_flags = {req_flags[F_Z], 0, 0, flags_lo[F_C]}; data1=a[15:8]. At the edge, latch the high result and go to RESP.
  - ADD16: ALU_ADC, data0=b[15:8].
  - INC16: ALU_ADC, data0=8'h00.
  - DEC16: ALU_SBC, data0=8'h00.
  - ADDSP: ALU_ADC, data0={8{b[7]}}.
  - All HIGH passes use size 16.
- RESP: rsp_valid=1 and rsp_data={res_hi,res_lo}.
  - rsp_flags for ADD16 = {req_flags[F_Z], 0, H_hi, C_hi}.
  - rsp_flags for INC16/DEC16 = req_flags unchanged.
  - rsp_flags for ADDSP = {0, 0, H_lo, C_lo}.
- rsp_valid, rsp_data and rsp_flags are held stable until rsp_ready=1. The handshake cycle returns the FSM to IDLE.
- Latency: accept at edge N; rsp_valid high in the cycle after edge N+2. A new request cannot be accepted in the same cycle as the response handshake (IDLE is required first). Throughput is 1 op per 4 cycles minimum.
- ALU C convention: for SUB/SBC, C=1 means borrow. The low-pass C is fed unmodified as the high-pass carry/borrow.
- Outside LOW/HIGH: alu_op=ALU_PASS0, alu_data0=alu_data1=0, alu_size=ALU_SIZE_8, alu_flags=0.
- Wrap-around: 0xFFFF+1 gives 0x0000; 0x0000-1 gives 0xFFFF. No overflow indication beyond C.
- Reset (asynchronous, any state including mid-op) sets the following:
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_flags=0.
  - All latches cleared; ALU outputs at their idle values.
  - An in-flight op is discarded.
- req_valid in a non-IDLE state is ignored; the requester must hold it.

Decomposition:
- cpu.vh (shared) gains SEQ_OP_ADD16/INC16/DEC16/ADDSP and SEQ state encodings, alongside the existing ALU_* and ALU_SIZE_* macros.
- No sub-module. The bench instantiates the existing alu and wires it to the alu_* ports.

Test Plan:
- ADD16 a=0x0FFF b=0x0001 flags=4'b1000 -> rsp_data=0x1000, rsp_flags=4'b1010; rsp_valid 3 cycles after accept.
- ADD16 a=0xFFFF b=0x0001 flags=0 -> rsp_data=0x0000, rsp_flags=4'b0011.
- INC16 a=0x00FF flags=4'b0101 -> 0x0100, flags 4'b0101; DEC16 a=0x0000 flags=4'b1110 -> 0xFFFF, flags 4'b1110.
- ADDSP a=0xFFF8 b=0x0008 -> 0x0000, flags 4'b0011; ADDSP a=0x1000 b=0x00FF -> 0x0FFF, flags 4'b0000.
- Hold rsp_ready=0 for 3 cycles -> rsp_valid/rsp_data stable, req_ready=0, a second request is not accepted until after the handshake plus one IDLE cycle.
- Assert reset_n=0 during HIGH -> rsp_valid=0 and req_ready=1 immediately. After release, ADD16 0x1234+0x1111 gives 0x2345, flags {Z_in,0,0,0}.
